// File: rtl/blink_tick_gen_if.sv
// Purpose : control/status bundle between the LED blinker controller and
//           the blink tick generator.
// Signals : key_n       raw pushbutton, active-low, asynchronous
//           enable      prescaler run enable
//           tick        one-cycle rate pulse
//           rate_sel    current rate index 0..3
//           key_pressed one-cycle pulse per accepted press
// master drives key_n/enable and observes the outputs; slave is the
// tick generator itself.
interface blink_tick_gen_if;
   logic       key_n;
   logic       enable;
   logic       tick;
   logic [1:0] rate_sel;
   logic       key_pressed;

   modport master (
      output key_n,
      output enable,
      input  tick,
      input  rate_sel,
      input  key_pressed
   );

   modport slave (
      input  key_n,
      input  enable,
      output tick,
      output rate_sel,
      output key_pressed
   );
endinterface

// File: rtl/blink_tick_gen.sv
// Purpose : debounces the board pushbutton, steps a 4-entry rate index on
//           each accepted press, and emits a one-cycle tick every
//           BASE_DIV >> rate_sel enabled cycles.
// Ports   : clock_50  system clock
//           reset     synchronous reset, active-high
//           bus       slave side of blink_tick_gen_if (key_n, enable in;
//                     tick, rate_sel, key_pressed out, all registered)
module blink_tick_gen #(
   parameter int unsigned BASE_DIV        = 50000000,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic             clock_50,
   input  logic             reset,
   blink_tick_gen_if.slave  bus
);

   localparam int unsigned CNT_W = 32;
   localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);

   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_0   = CNT_W'(BASE_DIV);

   logic             sync1_q,   sync1_d;
   logic             key_s_q,   key_s_d;
   logic             stable_q,  stable_d;
   logic [DB_W-1:0]  db_cnt_q,  db_cnt_d;
   logic [1:0]       rate_q,    rate_d;
   logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
   logic             tick_q,    tick_d;
   logic             press_q,   press_d;

   logic             db_accept;
   logic             press_evt;
   logic [CNT_W-1:0] div;
   logic             term;

   // Synchronizer, debounce and press detection
   always_comb begin
      sync1_d   = bus.key_n;
      key_s_d   = sync1_q;
      stable_d  = stable_q;
      db_cnt_d  = db_cnt_q;
      rate_d    = rate_q;
      press_d   = 1'b0;

      db_accept = (key_s_q != stable_q) && (db_cnt_q == DB_LAST);
      // Only a released->pressed transition counts as a press.
      press_evt = db_accept && stable_q;

      if (key_s_q == stable_q) begin
         db_cnt_d = '0;
      end else if (db_accept) begin
         stable_d = key_s_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + DB_W'(1);
      end

      if (press_evt) begin
         press_d = 1'b1;
         rate_d  = rate_q + 2'd1;
      end
   end

   // Prescaler; a rate change restarts the period and suppresses any
   // coincident terminal-count tick, regardless of enable.
   always_comb begin
      pre_cnt_d = pre_cnt_q;
      tick_d    = 1'b0;
      div       = DIV_0 >> rate_q;
      term      = (pre_cnt_q == (div - CNT_W'(1)));

      if (press_evt) begin
         pre_cnt_d = '0;
      end else if (bus.enable) begin
         if (term) begin
            pre_cnt_d = '0;
            tick_d    = 1'b1;
         end else begin
            pre_cnt_d = pre_cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clock_50) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         key_s_q   <= 1'b1;
         stable_q  <= 1'b1;
         db_cnt_q  <= '0;
         rate_q    <= '0;
         pre_cnt_q <= '0;
         tick_q    <= 1'b0;
         press_q   <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         key_s_q   <= key_s_d;
         stable_q  <= stable_d;
         db_cnt_q  <= db_cnt_d;
         rate_q    <= rate_d;
         pre_cnt_q <= pre_cnt_d;
         tick_q    <= tick_d;
         press_q   <= press_d;
      end
   end

   assign bus.tick        = tick_q;
   assign bus.rate_sel    = rate_q;
   assign bus.key_pressed = press_q;

endmodule

// File: tb/tb_blink_tick_gen.sv
// Purpose : scoreboard bench for blink_tick_gen with BASE_DIV=16 and
//           DEBOUNCE_CYCLES=4. The driver pushes hand-computed expected
//           events (edge number, kind, rate); a monitor pops and checks
//           each tick / key_pressed pulse the DUT presents.
module tb_blink_tick_gen;

   typedef struct {
      int         at;
      bit         is_press;
      logic [1:0] rate;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   failures;
   bit   done;
   exp_t exp_q[$];

   blink_tick_gen_if bus ();

   blink_tick_gen #(
      .BASE_DIV        (16),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clock_50 (clk),
      .reset    (reset),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Insert keeping the queue ordered by edge number.
   function automatic void push_exp(int at, bit is_press, logic [1:0] rate);
      exp_t e;
      int   i;
      e.at = at; e.is_press = is_press; e.rate = rate;
      i = 0;
      while (i < exp_q.size() && exp_q[i].at <= at) i++;
      exp_q.insert(i, e);
   endfunction

   function automatic void push_ticks(int first, int step, int limit, logic [1:0] rate);
      for (int c = first; c < limit; c += step) push_exp(c, 1'b0, rate);
   endfunction

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: edge %0d got %0d expected %0d", name, cyc, got, want);
      end
   endtask

   task automatic check_event(input bit is_press);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_%s: edge %0d rate_sel=%0d, nothing expected",
                  is_press ? "press" : "tick", cyc, bus.rate_sel);
      end else begin
         e = exp_q.pop_front();
         if (e.at != cyc || e.is_press != is_press || e.rate != bus.rate_sel) begin
            failures++;
            $display("FAIL event_%s: got edge %0d rate %0d; expected %s at edge %0d rate %0d",
                     is_press ? "press" : "tick", cyc, bus.rate_sel,
                     e.is_press ? "press" : "tick", e.at, e.rate);
         end
      end
   endtask

   // Monitor: sample 1 time unit after each rising edge.
   initial begin
      exp_t e;
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (!done) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
               e = exp_q.pop_front();
               checks++;
               failures++;
               $display("FAIL missing_%s: expected at edge %0d rate %0d, not seen",
                        e.is_press ? "press" : "tick", e.at, e.rate);
            end
            if (bus.key_pressed === 1'b1) check_event(1'b1);
            if (bus.tick === 1'b1)        check_event(1'b0);
         end
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Driver: inputs change on falling edges; edge k+1 samples them.
   initial begin
      checks      = 0;
      failures    = 0;
      done        = 1'b0;
      reset       = 1'b1;
      bus.key_n   = 1'b1;
      bus.enable  = 1'b1;

      // Reset state, then rate 0 cadence: ticks at 3+16, +32, +48
      wait_cyc(3);
      chk("rst_tick",  int'(bus.tick),        0);
      chk("rst_press", int'(bus.key_pressed), 0);
      chk("rst_rate",  int'(bus.rate_sel),    0);
      push_ticks(19, 16, 60, 2'd0);
      reset = 1'b0;

      // Valid press: accepted at 60+6, rate 1, tick 67 suppressed
      wait_cyc(60);
      push_exp(66, 1'b1, 2'd1);
      push_ticks(74, 8, 116, 2'd1);
      bus.key_n = 1'b0;
      wait_cyc(72);
      bus.key_n = 1'b1;

      // Three-cycle glitch: ignored, rate 1 cadence continues
      wait_cyc(90);
      bus.key_n = 1'b0;
      wait_cyc(93);
      bus.key_n = 1'b1;
      wait_cyc(100);
      chk("glitch_rate", int'(bus.rate_sel), 1);

      // Three more presses 40 apart; presses at 156/196 coincide with
      // terminal counts, so those ticks must not appear.
      wait_cyc(110);
      push_exp(116, 1'b1, 2'd2);
      push_ticks(120, 4, 156, 2'd2);
      push_exp(156, 1'b1, 2'd3);
      push_ticks(158, 2, 196, 2'd3);
      push_exp(196, 1'b1, 2'd0);
      bus.key_n = 1'b0;
      wait_cyc(122); bus.key_n = 1'b1;
      wait_cyc(150); bus.key_n = 1'b0;
      wait_cyc(162); bus.key_n = 1'b1;
      wait_cyc(190); bus.key_n = 1'b0;
      wait_cyc(202); bus.key_n = 1'b1;

      // Freeze at count=10 for edges 207..211; tick 6 enabled edges later
      wait_cyc(206);
      push_exp(217, 1'b0, 2'd0);
      bus.enable = 1'b0;
      wait_cyc(209);
      chk("freeze_tick", int'(bus.tick), 0);
      wait_cyc(211);
      bus.enable = 1'b1;
      chk("freeze_rate", int'(bus.rate_sel), 0);

      // Reset at edge 227 with key low 2 cycles and count 9
      wait_cyc(224);
      push_exp(233, 1'b1, 2'd1);
      push_ticks(241, 8, 270, 2'd1);
      bus.key_n = 1'b0;
      wait_cyc(226);
      reset = 1'b1;
      wait_cyc(227);
      chk("midrst_tick",  int'(bus.tick),        0);
      chk("midrst_press", int'(bus.key_pressed), 0);
      chk("midrst_rate",  int'(bus.rate_sel),    0);
      reset = 1'b0;
      wait_cyc(245);
      bus.key_n = 1'b1;

      wait_cyc(270);
      done = 1'b1;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
